// File: rtl/ahb_rr_arbiter_mux.sv
// rtl/ahb_rr_arbiter_mux.sv - AHB multi-master arbiter with address/data mux and default slave
//
// Purpose: grants one of NUM_MASTERS bus masters (burst- and lock-aware), routes the
// address-phase owner's controls and the data-phase owner's write data to the slave bank,
// decodes the slave select, and returns the data-phase slave's ready/response/read data.
// Unmapped NONSEQ/SEQ transfers get a two-cycle ERROR from a built-in default slave.
//
// Build option: define AHB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the
// lowest requesting master index wins.
//
// Ports:
//   hclk, hreset                  clock, asynchronous active-low reset
//   m_busreq, m_hlock             per-master request / locked-transfer request
//   m_haddr .. m_hwdata           packed per-master bus signals (master i at slice i)
//   hgrant                        one-hot registered grant
//   m_hready, m_hresp, m_hrdata   response returned to all masters
//   s_hsel                        one-hot slave select (all zero when unmapped)
//   s_haddr .. s_hburst           address-phase owner controls
//   s_hwdata                      data-phase owner write data
//   s_hmaster, s_hmastlock        address-phase owner index / lock
//   s_hready_out                  copy of m_hready for the slaves
//   s_hready, s_hresp, s_hrdata   packed per-slave responses
module ahb_rr_arbiter_mux #(
  parameter int NUM_MASTERS    = 4,
  parameter int NUM_SLAVES     = 4,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int DEFAULT_MASTER = NUM_MASTERS - 1,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_LO =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLAVE_HI =
    {32'h3FFF_FFFF, 32'h2FFF_FFFF, 32'h1FFF_FFFF, 32'h0FFF_FFFF},
  localparam int MW = $clog2(NUM_MASTERS),
  localparam int SW = $clog2(NUM_SLAVES + 1)
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic [NUM_MASTERS-1:0]        m_busreq,
  input  logic [NUM_MASTERS-1:0]        m_hlock,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
  input  logic [2*NUM_MASTERS-1:0]      m_htrans,
  input  logic [NUM_MASTERS-1:0]        m_hwrite,
  input  logic [3*NUM_MASTERS-1:0]      m_hsize,
  input  logic [3*NUM_MASTERS-1:0]      m_hburst,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata,
  output logic [NUM_MASTERS-1:0]        hgrant,
  output logic                          m_hready,
  output logic [1:0]                    m_hresp,
  output logic [DATA_W-1:0]             m_hrdata,
  output logic [NUM_SLAVES-1:0]         s_hsel,
  output logic [ADDR_W-1:0]             s_haddr,
  output logic [1:0]                    s_htrans,
  output logic                          s_hwrite,
  output logic [2:0]                    s_hsize,
  output logic [2:0]                    s_hburst,
  output logic [DATA_W-1:0]             s_hwdata,
  output logic [MW-1:0]                 s_hmaster,
  output logic                          s_hmastlock,
  output logic                          s_hready_out,
  input  logic [NUM_SLAVES-1:0]         s_hready,
  input  logic [2*NUM_SLAVES-1:0]       s_hresp,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_hrdata
);

  localparam logic [MW-1:0] DEF_M = MW'(DEFAULT_MASTER);
  localparam logic [SW-1:0] DEF_S = SW'(NUM_SLAVES);
  localparam logic [1:0] HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11;
  localparam logic [1:0] DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2;

  logic [MW-1:0]     arb_q, arb_d, addr_q, data_q, win;
  logic [SW-1:0]     dslv_q, dec_slv;
  logic [1:0]        ds_q, ds_d;
  logic [ADDR_W-1:0] hold_addr_q, a_haddr, dec_addr;
  logic              hrdy_q, a_busreq, found, hold;

  // Address-phase owner and data-phase owner muxes.
  always_comb begin
    a_haddr     = '0;
    s_htrans    = HT_IDLE;
    s_hwrite    = 1'b0;
    s_hsize     = '0;
    s_hburst    = '0;
    s_hmastlock = 1'b0;
    a_busreq    = 1'b0;
    s_hwdata    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (addr_q == MW'(i)) begin
        a_haddr     = m_haddr[i*ADDR_W +: ADDR_W];
        s_htrans    = m_htrans[i*2 +: 2];
        s_hwrite    = m_hwrite[i];
        s_hsize     = m_hsize[i*3 +: 3];
        s_hburst    = m_hburst[i*3 +: 3];
        s_hmastlock = m_hlock[i];
        a_busreq    = m_busreq[i];
      end
      if (data_q == MW'(i)) s_hwdata = m_hwdata[i*DATA_W +: DATA_W];
    end
  end

  // From the second wait cycle on, decode from the address captured in the first one.
  assign dec_addr  = hrdy_q ? a_haddr : hold_addr_q;
  assign s_haddr   = dec_addr;
  assign s_hmaster = addr_q;

  // Lowest matching slave index wins; no match selects the default slave.
  always_comb begin
    dec_slv = DEF_S;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (dec_addr >= SLAVE_LO[i] && dec_addr <= SLAVE_HI[i]) dec_slv = SW'(i);
    end
    for (int i = 0; i < NUM_SLAVES; i++) s_hsel[i] = (dec_slv == SW'(i));
  end

  // Response mux from the data-phase slave.
  always_comb begin
    m_hready = (ds_q != DS_ERR1);
    m_hresp  = (ds_q == DS_IDLE) ? 2'b00 : 2'b01;
    m_hrdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dslv_q == SW'(i)) begin
        m_hready = s_hready[i];
        m_hresp  = s_hresp[i*2 +: 2];
        m_hrdata = s_hrdata[i*DATA_W +: DATA_W];
      end
    end
  end
  assign s_hready_out = m_hready;

  // Default slave: ERR1 (wait, ERROR) then ERR2 (ready, ERROR) for every accepted unmapped
  // NONSEQ/SEQ; ERR2 may chain straight into another error.
  always_comb begin
    ds_d = DS_IDLE;
    if (ds_q == DS_ERR1) ds_d = DS_ERR2;
    else if (m_hready && dec_slv == DEF_S && s_htrans[1]) ds_d = DS_ERR1;
  end

  // Grant is frozen for a locked owner, for a burst in progress (including the NONSEQ that
  // opens a multi-beat burst, so the next beat stays with the same master) and during waits.
  assign hold = (m_busreq[arb_q] & m_hlock[arb_q])
              | (s_htrans == HT_SEQ) | (s_htrans == HT_BUSY)
              | ((s_htrans == HT_NONSEQ) && (s_hburst != 3'b000) && a_busreq)
              | !m_hready;

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [MW-1:0] rr_q, rr_d;

  always_comb begin
    win   = DEF_M;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      logic [MW-1:0] cand;
      cand = MW'((int'(rr_q) + k) % NUM_MASTERS);
      if (!found && m_busreq[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    rr_d = rr_q;
    if (!hold && found) rr_d = (int'(win) == NUM_MASTERS - 1) ? '0 : MW'(int'(win) + 1);
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`else
  always_comb begin
    win   = DEF_M;
    found = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (m_busreq[k]) begin
        win   = MW'(k);
        found = 1'b1;
      end
    end
  end
`endif

  assign arb_d = hold ? arb_q : (found ? win : DEF_M);

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) hgrant[i] = (arb_q == MW'(i));
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      arb_q       <= DEF_M;
      addr_q      <= DEF_M;
      data_q      <= DEF_M;
      dslv_q      <= DEF_S;
      ds_q        <= DS_IDLE;
      hold_addr_q <= '0;
      hrdy_q      <= 1'b1;
    end else begin
      arb_q       <= arb_d;
      ds_q        <= ds_d;
      hold_addr_q <= dec_addr;
      hrdy_q      <= m_hready;
      if (m_hready) begin
        addr_q <= arb_q;
        data_q <= addr_q;
        dslv_q <= dec_slv;
      end
    end
  end

endmodule
